// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   uart_state_e   : serializer FSM states (IDLE, START, DATA, PARITY, STOP)
//   UART_IDLE_LVL  : line level while idle and during stop bits
//   UART_START_LVL : line level of the start bit
//   uart_parity()  : parity of a data word (even sense, inverted when odd=1)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Unused upper bits must be zero; they do not disturb the XOR.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period divider: counts 0..CLK_DIV-1 while enabled and flags the last
// count as a bit tick, then wraps to zero.
//   clk  in  : block clock
//   rst  in  : asynchronous active-high reset
//   clr  in  : synchronous clear of the divider (held while the line is idle)
//   en   in  : count enable (a frame is in progress)
//   tick out : last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter: cleared on request, wraps after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en && !clr && (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter: bytes enter a FIFO through a valid/ready handshake and are
// sent LSB-first as start bit, data bits, optional parity bit and stop bit(s).
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit and state).
//   clk        in  : block clock
//   rst        in  : asynchronous active-high reset (flushes FIFO, abandons frame)
//   tx_data    in  : byte to send
//   tx_valid   in  : tx_data valid this cycle
//   tx_ready   out : FIFO not full
//   tx         out : serial line, idles high (registered)
//   busy       out : frame in progress or FIFO non-empty
//   fifo_level out : bytes held in the FIFO
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic                 tx_ready_r;
  logic                 busy_r;
  logic                 tx_r;
  uart_state_e          state_r;
  // Data bits with the parity bit parked above the MSB; it reaches bit 1
  // exactly when the last data bit is on the line.
  logic [DATA_BITS:0]   shift_r;
  logic [2:0]           bit_cnt_r;

  logic                 tick_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 stop_done_s;
  logic                 idle_nxt_s;
  logic [LVL_W-1:0]     level_nxt_s;
  logic [DATA_BITS:0]   frame_s;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_r == IDLE),
    .en   (state_r != IDLE),
    .tick (tick_s)
  );

  // Handshake, pop decision and next FIFO level.
  always_comb begin
    push_s      = tx_valid && tx_ready_r;
    stop_done_s = (state_r == STOP) && tick_s && (bit_cnt_r == LAST_STOP);
    pop_s       = ((state_r == IDLE) || stop_done_s) && (level_r != '0);
    idle_nxt_s  = ((state_r == IDLE) || stop_done_s) && (level_r == '0);
    frame_s     = {uart_parity(8'(mem_r[rd_ptr_r]), PAR_ODD), mem_r[rd_ptr_r]};
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers, level and the registered ready/busy status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      wr_ptr_r   <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
      rd_ptr_r   <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
      level_r    <= level_nxt_s;
      tx_ready_r <= (level_nxt_s != LVL_FULL);
      busy_r     <= !idle_nxt_s || (level_nxt_s != '0);
    end
  end

  // Frame FSM; tx is loaded with the level of the bit entered on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= 3'd0;
      tx_r      <= UART_IDLE_LVL;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            shift_r   <= frame_s;
            bit_cnt_r <= 3'd0;
            state_r   <= START;
            tx_r      <= UART_START_LVL;
          end else begin
            tx_r      <= UART_IDLE_LVL;
          end
        end
        START: begin
          if (tick_s) begin
            bit_cnt_r <= 3'd0;
            state_r   <= DATA;
            tx_r      <= shift_r[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r <= shift_r >> 1;
            if (bit_cnt_r == LAST_DATA) begin
              bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state_r   <= PARITY;
              tx_r      <= shift_r[1];
`else
              state_r   <= STOP;
              tx_r      <= UART_IDLE_LVL;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= shift_r[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_s) begin
            bit_cnt_r <= 3'd0;
            state_r   <= STOP;
            tx_r      <= UART_IDLE_LVL;
          end
        end
`endif
        STOP: begin
          if (tick_s) begin
            if (bit_cnt_r != LAST_STOP) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end else if (pop_s) begin
              // Next frame starts with no idle gap.
              shift_r   <= frame_s;
              bit_cnt_r <= 3'd0;
              state_r   <= START;
              tx_r      <= UART_START_LVL;
            end else begin
              state_r   <= IDLE;
              tx_r      <= UART_IDLE_LVL;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= 3'd0;
          tx_r      <= UART_IDLE_LVL;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign tx_ready   = tx_ready_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
// Bench for uart_tx_serializer with CLK_DIV=4, DATA_BITS=8, FIFO_DEPTH=4.
// u_dut uses STOP_BITS=1 and is tracked every cycle by a queue-based line
// model; u_dut2 uses STOP_BITS=2. Parity expectations follow UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F1 = (1 + 8 + P + 1) * CLK_DIV;
  localparam int F2 = (1 + 8 + P + 2) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;
  logic [2:0] fifo_level;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2;
  logic [2:0] fifo_level2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .busy(busy), .fifo_level(fifo_level));

  uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx(tx2), .busy(busy2), .fifo_level(fifo_level2));

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (u_dut) ----------------
  // FIFO is a queue of bytes; the line is "rem" cycles left of a frame whose
  // bit sequence is fb[]. A frame may start when idle or on its last cycle.
  logic [7:0] mq[$];
  int         rem = 0;
  bit         fb[16];
  bit         model_on = 1'b0;

  task automatic model_step();
    bit         acc;
    logic [7:0] d;
    if (rst) begin
      mq.delete();
      rem = 0;
    end else begin
      acc = tx_valid && (mq.size() < 4);
      if (rem > 1) begin
        rem--;
      end else if (mq.size() > 0) begin
        d = mq.pop_front();
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
        if (P == 1) fb[9] = ^d;
        fb[9 + P] = 1'b1;
        rem = F1;
      end else begin
        rem = 0;
      end
      if (acc) mq.push_back(tx_data);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("model_tx", tx, (rem == 0) ? 1 : int'(fb[(F1 - rem) / CLK_DIV]));
        check("model_level", fifo_level, mq.size());
        check("model_ready", tx_ready, (mq.size() < 4) ? 1 : 0);
        check("model_busy", busy, (rem != 0 || mq.size() != 0) ? 1 : 0);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || fifo_level != 3'd0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];
  bit   samp[256];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int run;
    int e;
    int act;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h3C, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    model_on = 1'b1;
    @(negedge clk);

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      wait_idle(200);
      tx_data  = vecs[v].data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("pre_start_tx", tx, 1);
      n = 0;
      do begin
        @(negedge clk);
        samp[n] = tx;
        n++;
      end while (busy && n < 200);
      check("frame_len", n - 1, F1);
      for (int b = 0; b < F1 / CLK_DIV; b++) begin
        if (b == 0) e = 0;
        else if (b <= 8) e = int'(vecs[v].data[b - 1]);
        else if (P == 1 && b == 9) e = int'(vecs[v].exp_par);
        else e = 1;
        act = e;
        for (int c = 0; c < CLK_DIV; c++) begin
          if (int'(samp[b * CLK_DIV + c]) != e) act = int'(samp[b * CLK_DIV + c]);
        end
        check($sformatf("vec%0d_bit%0d", v, b), act, e);
      end
    end

    // Burst of five plus two ignored writes while full
    wait_idle(200);
    n = 0;
    for (int i = 1; i <= 7; i++) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
      n++;
      if (i == 5) begin
        check("burst_level_full", fifo_level, 4);
        check("burst_ready_low", tx_ready, 0);
      end
    end
    tx_valid = 1'b0;
    check("burst_ignored_level", fifo_level, 4);
    while (busy && n < 6 * F1) begin
      @(negedge clk);
      n++;
    end
    check("burst_back_to_back", n, 5 * F1 + 2);

    // Push and pop in the same cycle at level 2
    wait_idle(200);
    for (int i = 0; i < 3; i++) begin
      tx_data  = 8'h11 * 8'(i + 1);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("pp_level_before", fifo_level, 2);
    repeat (F1 - 2) @(negedge clk);
    check("pp_level_pre_edge", fifo_level, 2);
    tx_data  = 8'h44;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("pp_level_same", fifo_level, 2);
    check("pp_next_start", tx, 0);
    wait_idle(5 * F1);

    // Reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_frame_tx_low", tx, 0);
    check("mid_frame_level", fifo_level, 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 0;
    repeat (60) begin
      @(negedge clk);
      if (!tx || busy) run++;
    end
    check("no_resume_after_rst", run, 0);

    // Randomized traffic: dense phase then sparse phase
    for (int c = 0; c < 600; c++) begin
      tx_data  = 8'($urandom);
      tx_valid = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle(6 * F1);

    // STOP_BITS=2 instance, byte 0xFF
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    n   = 0;
    run = 0;
    do begin
      @(negedge clk);
      n++;
      if (tx2) run++;
      else run = 0;
    end while (busy2 && n < 200);
    check("stop2_frame_len", n - 1, F2);
    check("stop2_final_high", run - 1, (P == 1) ? 8 : 40);
    check("stop2_idle_tx", tx2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Design-side UART transmitter that drives the serial line carried by the UART VIP interface, giving the VIP's receive monitor a real source to check. Parallel bytes enter through a valid/ready handshake into a small FIFO. Each byte is serialized LSB-first as start bit, data bits, optional parity bit and stop bit(s), using a programmable clock divider.

## Interface
- CLK_DIV, 16: clock cycles per bit; legal values are 2 or more.
- DATA_BITS, 8: data bits per frame; legal range 5–8.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- FIFO_DEPTH, 4: transmit FIFO entries; must be a power of two, 2 or more.
- PARITY_ODD, 0: parity sense (0 even, 1 odd); used only when parity is compiled in.

- clk  in  1  single clock for the block.
- rst  in  1  reset; asynchronous, active-high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte (not full).
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress, or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of bytes in the FIFO.

## Operation
- Reset values:
  - tx=1, tx_ready=1, busy=0, fifo_level=0.
  - FSM is in IDLE; divider and bit counters are 0.
- Handshake:
  - A byte is written when tx_valid && tx_ready at a rising edge.
  - tx_valid while full is ignored; no data is lost or overwritten.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, go to START, clear the divider.
  - START: tx=0. On bit tick, go to DATA with bit_cnt=0.
  - DATA: tx=shift[0]. On tick, shift right and increment bit_cnt. After bit DATA_BITS-1, go to PARITY (if compiled in) or STOP.
  - PARITY: tx = XOR of data bits, XOR PARITY_ODD. On tick, go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods. On the final tick:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Bit tick is asserted when the divider reaches CLK_DIV-1; the divider then wraps to 0.
- Simultaneous push and pop in one cycle: fifo_level is unchanged. A push into a full FIFO that pops in the same cycle is still refused (tx_ready reflects full only).
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty are derived from fifo_level.
- Reset asserted mid-frame:
  - tx returns to 1 asynchronously;
  - the FIFO is flushed and the frame is abandoned;
  - no partial frame resumes after release.

## Timing
- tx is a registered output with no combinational path from the inputs.
- Idle, empty FIFO, byte accepted at edge N: FIFO visible at N+1, FSM pops at N+1, tx falls after edge N+1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, where P=1 if parity is compiled in, else 0.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- tx_ready deasserts in the cycle after the write that fills the FIFO. It reasserts in the cycle after a pop.
- busy falls in the cycle after the final stop-bit period, provided the FIFO is empty.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state and parity bit are present, and PARITY_ODD selects the sense.
  - Undefined: no parity bit is sent, the PARITY state is not synthesized, and PARITY_ODD is ignored.
  - Port list is identical in both cases.

## Structure
- Package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the line-level constants UART_IDLE_LVL=1 and UART_START_LVL=0.
- Sub-module uart_baud_gen:
  - parameter CLK_DIV;
  - inputs clr and en; output tick;
  - counter width $clog2(CLK_DIV).
- FIFO and FSM stay in the top block.

## Test plan
All scenarios use CLK_DIV=4, DATA_BITS=8, STOP_BITS=1.
- Single byte 0xA5, parity off: tx goes low after the accept edge +1. Then 4 cycles each of 1,0,1,0,0,1,0,1; then high. Frame is 40 cycles, then busy=0.
- Parity on, PARITY_ODD=0, byte 0x07: parity bit=1. Frame is 44 cycles.
- Write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles:
  - the first pops immediately; the next four fill the FIFO (fifo_level=4, tx_ready=0);
  - further tx_valid is ignored;
  - all five frames are sent back-to-back with no idle cycles.
- Push and pop in the same cycle at fifo_level=2: fifo_level stays 2 and data order is preserved.
- Assert rst during bit 3 of a frame with 2 bytes queued: tx=1 immediately, fifo_level=0. After release, the line stays idle.
- STOP_BITS=2, byte 0xFF: high stop level lasts 8 cycles. Frame is 44 cycles.
